// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared divider definitions: FSM encoding and divide-by-zero result
//
// Contents:
//   div_state_t   : divider control states (IDLE, RUN, DONE)
//   DIV_MAX_WIDTH : widest operand the divider supports
//   DIV_ZERO_Q    : quotient returned on divide by zero (all ones), sliced to WIDTH by users
package div_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    localparam int DIV_MAX_WIDTH = 64;

    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_Q = '1;

endpackage

// File: rtl/div_unit_abs_neg.sv
// rtl/div_unit_abs_neg.sv - combinational two's-complement conditional negate
//
// Module div_abs_neg: o_val = i_neg ? -i_val : i_val.
// Used both to take operand magnitudes (i_neg = operand sign) and to apply
// the result signs after the unsigned iteration.
//   i_val : WIDTH-bit input value
//   i_neg : negate when high
//   o_val : WIDTH-bit result
module div_abs_neg
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    // The most negative value maps onto itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed here.
    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 signed/unsigned divider, falling-edge clocked
//
// Ports:
//   clock     : only clock, all state changes on the falling edge
//   reset     : asynchronous active-low reset
//   start     : request a division (sampled only in IDLE)
//   sign_mode : 1 = signed, 0 = unsigned, latched with the operands
//   abort     : flush any in-flight operation, wins over start
//   dividend  : numerator, latched on an accepted start
//   divisor   : denominator, latched on an accepted start
//   q, r      : registered quotient / remainder, updated only with done
//   busy      : high from the accepting edge until the edge raising done
//   done      : one-cycle pulse, WIDTH+1 edges after the accepting edge
//   div_zero  : set with done when the latched divisor was zero
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_rem;      // partial remainder magnitude
    logic [WIDTH-1:0] r_dvs;      // divisor magnitude
    logic [WIDTH-1:0] r_dvd;      // raw dividend, returned as remainder on divide by zero
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_dz;

    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    assign w_dvd_neg = sign_mode & dividend[WIDTH-1];
    assign w_dvs_neg = sign_mode & divisor[WIDTH-1];

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .i_val (dividend),
        .i_neg (w_dvd_neg),
        .o_val (w_dvd_abs)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .i_val (divisor),
        .i_neg (w_dvs_neg),
        .o_val (w_dvs_abs)
    );

    // Restoring step: the shifted remainder carries one guard bit so that
    // values up to 2*divisor-1 compare correctly. When the trial subtraction
    // succeeds the true difference is below the divisor, so the low WIDTH
    // bits of a modular subtract are exact.
    assign w_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_diff  = w_shift[WIDTH-1:0] - r_dvs;

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (
        .i_val (r_quo),
        .i_neg (r_q_neg),
        .o_val (w_q_fix)
    );

    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (
        .i_val (r_rem),
        .i_neg (r_r_neg),
        .o_val (w_r_fix)
    );

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_dvd    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
            q        <= '0;
            r        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        r_state <= ST_RUN;
                        r_cnt   <= CNT_W'(WIDTH);
                        r_quo   <= w_dvd_abs;
                        r_rem   <= '0;
                        r_dvs   <= w_dvs_abs;
                        r_dvd   <= dividend;
                        r_q_neg <= w_dvd_neg ^ w_dvs_neg;
                        r_r_neg <= w_dvd_neg;
                        r_dz    <= (divisor == '0);
                        busy    <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        busy    <= 1'b0;
                    end else begin
                        if (w_ge) begin
                            r_rem <= w_diff;
                            r_quo <= {r_quo[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_shift[WIDTH-1:0];
                            r_quo <= {r_quo[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt - CNT_W'(1);
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // Sign fix-up and result publication share this edge, so
                    // done lands on the edge after the last iteration.
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                    if (!abort) begin
                        done     <= 1'b1;
                        div_zero <= r_dz;
                        q        <= r_dz ? DIV_ZERO_Q[WIDTH-1:0] : w_q_fix;
                        r        <= r_dz ? r_dvd : w_r_fix;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit (WIDTH=32 and WIDTH=8 instances)
module tb_div_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          edge_no;
    } exp_t;

    logic        clock;
    logic        rst_n;

    logic        start32, sm32, abort32;
    logic [31:0] dvd32, dvs32, q32o, r32o;
    logic        busy32, done32, dz32;

    logic        start8, sm8, abort8;
    logic [7:0]  dvd8, dvs8, q8o, r8o;
    logic        busy8, done8, dz8;

    exp_t        sb32[$];
    exp_t        sb8[$];
    int          edge_cnt;
    int          n_pass;
    int          n_total;

    div_unit #(.WIDTH(32)) dut32 (
        .clock     (clock),
        .reset     (rst_n),
        .start     (start32),
        .sign_mode (sm32),
        .abort     (abort32),
        .dividend  (dvd32),
        .divisor   (dvs32),
        .q         (q32o),
        .r         (r32o),
        .busy      (busy32),
        .done      (done32),
        .div_zero  (dz32)
    );

    div_unit #(.WIDTH(8)) dut8 (
        .clock     (clock),
        .reset     (rst_n),
        .start     (start8),
        .sign_mode (sm8),
        .abort     (abort8),
        .dividend  (dvd8),
        .divisor   (dvs8),
        .q         (q8o),
        .r         (r8o),
        .busy      (busy8),
        .done      (done8),
        .div_zero  (dz8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial edge_cnt = 0;
    always @(negedge clock) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitors: outputs sampled on the rising edge, half a cycle after update.
    always @(posedge clock) begin : mon32
        exp_t e;
        if (done32) begin
            if (sb32.size() == 0) begin
                check("spurious_done32", 64'd1, 64'd0);
            end else begin
                e = sb32.pop_front();
                check("q32", {32'd0, q32o}, {32'd0, e.q});
                check("r32", {32'd0, r32o}, {32'd0, e.r});
                check("dz32", {63'd0, dz32}, {63'd0, e.dz});
                check("done_edge32", 64'(edge_cnt), 64'(e.edge_no));
            end
        end
    end

    always @(posedge clock) begin : mon8
        exp_t e;
        if (done8) begin
            if (sb8.size() == 0) begin
                check("spurious_done8", 64'd1, 64'd0);
            end else begin
                e = sb8.pop_front();
                check("q8", {56'd0, q8o}, {32'd0, e.q});
                check("r8", {56'd0, r8o}, {32'd0, e.r});
                check("dz8", {63'd0, dz8}, {63'd0, e.dz});
                check("done_edge8", 64'(edge_cnt), 64'(e.edge_no));
            end
        end
    end

    // Called just after a rising edge; the following falling edge accepts.
    task automatic issue32(input logic [31:0] a, input logic [31:0] b, input logic sm,
                           input logic [31:0] eq, input logic [31:0] er, input logic edz,
                           input bit push);
        dvd32   = a;
        dvs32   = b;
        sm32    = sm;
        start32 = 1'b1;
        if (push) sb32.push_back('{eq, er, edz, edge_cnt + 34});
    endtask

    task automatic wait32(input bit noise);
        repeat (33) begin
            @(posedge clock);
            start32 = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                dvd32 = $urandom;
                dvs32 = $urandom;
            end
        end
    endtask

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic [7:0] eq, input logic [7:0] er, input logic edz);
        dvd8   = a;
        dvs8   = b;
        sm8    = sm;
        start8 = 1'b1;
        sb8.push_back('{{24'd0, eq}, {24'd0, er}, edz, edge_cnt + 10});
    endtask

    task automatic wait8();
        repeat (9) begin
            @(posedge clock);
            start8 = 1'b0;
        end
    endtask

    task automatic check_zero32(input string tag);
        check({tag, "_q32"}, {32'd0, q32o}, 64'd0);
        check({tag, "_r32"}, {32'd0, r32o}, 64'd0);
        check({tag, "_busy32"}, {63'd0, busy32}, 64'd0);
        check({tag, "_done32"}, {63'd0, done32}, 64'd0);
        check({tag, "_dz32"}, {63'd0, dz32}, 64'd0);
    endtask

    task automatic check_zero8(input string tag);
        check({tag, "_q8"}, {56'd0, q8o}, 64'd0);
        check({tag, "_r8"}, {56'd0, r8o}, 64'd0);
        check({tag, "_busy8"}, {63'd0, busy8}, 64'd0);
        check({tag, "_dz8"}, {63'd0, dz8}, 64'd0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        start32 = 1'b0; sm32 = 1'b0; abort32 = 1'b0; dvd32 = '0; dvs32 = '0;
        start8  = 1'b0; sm8  = 1'b0; abort8  = 1'b0; dvd8  = '0; dvs8  = '0;

        repeat (2) @(posedge clock);
        check_zero32("reset");
        check_zero8("reset");
        rst_n = 1'b1;

        // Narrow instance: 200/13, -128/-1, -100/7
        @(posedge clock); issue8(8'd200, 8'd13, 1'b0, 8'd15, 8'd5, 1'b0);   wait8();
        @(posedge clock); issue8(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);   wait8();
        @(posedge clock); issue8(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0);   wait8();

        // Wide instance, issued back to back every WIDTH+2 edges
        @(posedge clock); issue32(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1);                    wait32(1'b0);
        @(posedge clock); issue32(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1); wait32(1'b0);
        @(posedge clock); issue32(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 1'b1);         wait32(1'b0);
        @(posedge clock); issue32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1); wait32(1'b0);
        @(posedge clock); issue32(32'd12345, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd12345, 1'b1, 1'b1);         wait32(1'b0);
        @(posedge clock); issue32(32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1, 1'b1); wait32(1'b0);
        @(posedge clock); issue32(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b1);         wait32(1'b0);
        @(posedge clock); issue32(32'd1000, 32'd33, 1'b0, 32'd30, 32'd10, 1'b0, 1'b1);                   wait32(1'b1);
        @(posedge clock); issue32(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b1); wait32(1'b0);

        // Abort during iteration 10, then restart on the next cycle
        @(posedge clock); issue32(32'hDEAD_BEEF, 32'h10, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clock); start32 = 1'b0;
        repeat (9) @(posedge clock);
        check("busy_run32", {63'd0, busy32}, 64'd1);
        abort32 = 1'b1;
        @(posedge clock);
        abort32 = 1'b0;
        check("abort_busy32", {63'd0, busy32}, 64'd0);
        check("abort_done32", {63'd0, done32}, 64'd0);
        check("abort_q32", {32'd0, q32o}, 64'd14);
        check("abort_r32", {32'd0, r32o}, 64'hFFFF_FFFE);
        check("abort_dz32", {63'd0, dz32}, 64'd0);
        issue32(32'd5000, 32'd7, 1'b0, 32'd714, 32'd2, 1'b0, 1'b1);
        wait32(1'b0);

        // Abort in IDLE blocks a simultaneous start
        @(posedge clock); start32 = 1'b1; abort32 = 1'b1; dvd32 = 32'd9; dvs32 = 32'd3;
        @(posedge clock); start32 = 1'b0; abort32 = 1'b0;
        check("idle_abort_busy32", {63'd0, busy32}, 64'd0);

        // Reset at iteration 5, released two cycles later with start already up
        @(posedge clock); issue32(32'd777, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        @(posedge clock); start32 = 1'b0;
        repeat (4) @(posedge clock);
        rst_n = 1'b0;
        @(posedge clock);
        check_zero32("midrst");
        check_zero8("midrst");
        @(posedge clock);
        rst_n = 1'b1;
        issue32(32'd200000, 32'd300, 1'b0, 32'd666, 32'd200, 1'b0, 1'b1);
        wait32(1'b0);

        repeat (3) @(posedge clock);
        check("pending32", 64'(sb32.size()), 64'd0);
        check("pending8", 64'(sb8.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal range 4..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, meaning iteration counter width (derived, not overridden).
REQ-003 SHALL have port clock  input  1  the only clock; all state updates occur on its falling edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-006 SHALL have port sign_mode  input  1  1 = signed (div), 0 = unsigned (divu); latched with operands.
REQ-007 SHALL have port abort  input  1  cancel in-flight operation (exception flush).
REQ-008 SHALL have port dividend  input  WIDTH  numerator, latched on accepted start.
REQ-009 SHALL have port divisor  input  WIDTH  denominator, latched on accepted start.
REQ-010 SHALL have port q  output  WIDTH  registered quotient.
REQ-011 SHALL have port r  output  WIDTH  registered remainder.
REQ-012 SHALL have port busy  output  1  high while an operation is in progress.
REQ-013 SHALL have port done  output  1  one-cycle pulse when q/r become valid.
REQ-014 SHALL have port div_zero  output  1  set with done when the latched divisor was zero.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after WIDTH iterations; DONE->IDLE unconditionally on the next edge.
REQ-016 SHALL latch dividend, divisor, sign_mode, operand magnitudes and result signs on the accepting edge; later input changes SHALL NOT affect the result.
REQ-017 SHALL perform one radix-2 restoring or non-restoring step per edge in RUN, on unsigned magnitudes of WIDTH bits plus one guard bit.
REQ-018 SHALL assert done exactly WIDTH+1 falling edges after the accepting edge; busy SHALL be high from the accepting edge until the edge that asserts done.
REQ-019 SHALL update q, r, div_zero only on the edge that asserts done and hold them until the next done or reset.
REQ-020 SHALL, in signed mode, negate q when operand signs differ and give r the sign of the dividend; |r| < |divisor|.
REQ-021 SHALL produce, for signed most-negative / -1, q = most-negative value and r = 0, with no flag.
REQ-022 SHALL produce, on divisor zero (either mode), q = all ones, r = dividend, div_zero = 1, at normal latency.
REQ-023 SHALL ignore start while busy or in DONE; a start in the IDLE cycle after DONE SHALL be accepted (back-to-back issue every WIDTH+2 edges).
REQ-024 SHALL, on abort high in RUN or DONE, go to IDLE on that edge, drop busy, suppress done, and leave q/r/div_zero unchanged; abort has priority over start.
REQ-025 SHALL, on abort in IDLE with start high, not accept the start.

Reset
REQ-026 SHALL, when reset is low, asynchronously force state IDLE, busy 0, done 0, div_zero 0, q 0, r 0, counter 0, including mid-operation.
REQ-027 SHALL accept no start while reset is low; the first falling edge after release may accept a start.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, RUN, DONE) and the divide-by-zero result constant in the shared CPU package.
REQ-029 SHALL use one sub-module, div_abs_neg, a combinational two's-complement magnitude/negate helper instantiated for operand abs and result fix-up.

Verification
REQ-030 Unsigned WIDTH=32: dividend 100, divisor 7, sign_mode 0 -> q 14, r 2, done at edge 33, div_zero 0.
REQ-031 Signed: -7 / 2 -> q -3 (0xFFFFFFFD), r -1 (0xFFFFFFFF); 7 / -2 -> q -3, r 1.
REQ-032 Corner cases: 0x80000000 / 0xFFFFFFFF signed -> q 0x80000000, r 0; any / 0 -> q 0xFFFFFFFF, r dividend, div_zero 1.
REQ-033 Operand hold: change dividend/divisor every cycle after start; result equals the latched operands; start pulses during busy are ignored.
REQ-034 Abort at iteration 10 -> busy low next edge, no done, previous q/r retained; new start next cycle -> correct result.
REQ-035 Reset low at iteration 5, released 2 cycles later -> all outputs 0, IDLE; WIDTH=8 instance: 200/13 unsigned -> q 15, r 5 at edge 9.
